pipelined_cla_adder: RTL

// Parametrised, pipelined carry-lookahead adder/subtractor for WIDTH-bit operands.
// The operand is split into BLOCK-bit lookahead groups. Each group has generate
// g=a&b, propagate p=a^b and lookahead carries, and sits in its own pipeline stage.

---
 rtl/pipelined_cla_adder_if.sv | 27 ++
 rtl/pipelined_cla_adder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready operand and result bundle for pipelined_cla_adder.
// The master side is the producer/consumer pair, and the slave side is the adder.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, c, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, c, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor. Each pipeline stage resolves one
// BLOCK-bit lookahead group and forwards its carry and the unsummed operand bits.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned BLOCK = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int unsigned NGRP = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || BLOCK < 2 || BLOCK > 8) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK, BLOCK in 2..8");
  end

  logic             adv;
  logic [WIDTH-1:0] bb;
  logic             cin;

  assign bb           = bus.sub ? ~bus.b : bus.b;
  assign cin          = bus.sub | bus.c;
  assign adv          = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    // Operand bits still to be summed at this stage, and sum bits completed here.
    localparam int unsigned InW  = WIDTH - k * BLOCK;
    localparam int unsigned SumW = (k + 1) * BLOCK;

    logic             vin;
    logic             c_in;
    logic [InW-1:0]   a_in;
    logic [InW-1:0]   b_in;
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] gsum;
    logic [BLOCK:0]   carr;
    logic             prod;
    logic             cy;
    logic [SumW-1:0]  s_d;
    logic             vld_q;
    logic             cy_q;
    logic [SumW-1:0]  s_q;

    if (k == 0) begin : g_src
      assign vin  = bus.in_valid;
      assign c_in = cin;
      assign a_in = bus.a;
      assign b_in = bb;
      assign s_d  = gsum;
    end else begin : g_src
      assign vin  = g_stage[k-1].vld_q;
      assign c_in = g_stage[k-1].cy_q;
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign s_d  = {gsum, g_stage[k-1].s_q};
    end

    // Each carry is a flat sum of products over g/p/c_in; no carry feeds another.
    always_comb begin
      p       = a_in[BLOCK-1:0] ^ b_in[BLOCK-1:0];
      g       = a_in[BLOCK-1:0] & b_in[BLOCK-1:0];
      carr    = '0;
      prod    = 1'b0;
      cy      = 1'b0;
      carr[0] = c_in;
      for (int i = 0; i < BLOCK; i++) begin
        prod = p[i];
        cy   = g[i];
        for (int j = i - 1; j >= 0; j--) begin
          cy   = cy | (prod & g[j]);
          prod = prod & p[j];
        end
        carr[i+1] = cy | (prod & c_in);
      end
      gsum = p ^ carr[BLOCK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        s_q   <= '0;
      end else if (adv) begin
        vld_q <= vin;
        if (vin) begin
          cy_q <= carr[BLOCK];
          s_q  <= s_d;
        end
      end
    end

    if (k < NGRP - 1) begin : g_fwd
      logic [InW-BLOCK-1:0] a_q;
      logic [InW-BLOCK-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && vin) begin
          a_q <= a_in[InW-1:BLOCK];
          b_q <= b_in[InW-1:BLOCK];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && vin) begin
          ovf_q <= carr[BLOCK] ^ carr[BLOCK-1];
        end
      end

      assign bus.out_valid = vld_q;
      assign bus.s         = s_q;
      assign bus.cout      = cy_q;
      assign bus.ovf       = ovf_q;
    end
  end
endmodule
